// File: rtl/path_equiv_pkg.sv
// rtl/path_equiv_pkg.sv - shared path identifiers and the stage record layout for path_equiv_pipe
package path_equiv_pkg;

  typedef enum logic [1:0] {
    PATH_CONT = 2'd0,
    PATH_PROC = 2'd1,
    PATH_BUF  = 2'd2,
    PATH_AND  = 2'd3
  } path_e;

  localparam int NUM_PATHS = 4;
  localparam int PE_WIDTH  = 8;

  // Default-width stage record; the stage module rebuilds the same layout at its own WIDTH.
  typedef struct packed {
    logic                                 valid;
    logic [NUM_PATHS-1:0][PE_WIDTH-1:0]   path;
  } stage_t;

endpackage

// File: rtl/path_equiv_stage.sv
// rtl/path_equiv_stage.sv - one valid/data register stage: valid shifts every edge, data loads on valid
module path_equiv_stage
  import path_equiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  input  logic [NUM_PATHS-1:0][WIDTH-1:0]   i_data,
  output logic                              o_valid,
  output logic [NUM_PATHS-1:0][WIDTH-1:0]   o_data
);

  typedef struct packed {
    logic                               valid;
    logic [NUM_PATHS-1:0][WIDTH-1:0]    path;
  } stage_w_t;

  stage_w_t r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage.valid <= i_valid;
      if (i_valid) begin
        r_stage.path <= i_data;
      end
    end
  end

  assign o_valid = r_stage.valid;
  assign o_data  = r_stage.path;

endmodule

// File: rtl/path_equiv_pipe.sv
// rtl/path_equiv_pipe.sv - four equivalent paths, DEPTH-stage pipeline, tail compare with error capture
// Optional 4-state checking at the tail is enabled by defining PATH_EQUIV_XCHK_EN.
module path_equiv_pipe
  import path_equiv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  inj_mask,
  input  logic              clr_err,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              mismatch,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        first_err_path
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_p1;
  logic [WIDTH-1:0] w_p2;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_p3;

  assign w_p0 = in_data;

  always_comb begin
    w_p1 = in_data;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    buf u_buf (w_p2[i], in_data[i]);
    and u_and (w_and[i], in_data[i], in_data[i]);
  end

  assign w_p3 = w_and ^ inj_mask;

  logic [DEPTH:0]                      w_v;
  logic [NUM_PATHS-1:0][WIDTH-1:0]     w_d [DEPTH+1];

  assign w_v[0] = in_valid;
  assign w_d[0] = {w_p3, w_p2, w_p1, w_p0};

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    path_equiv_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_v[s]),
      .i_data  (w_d[s]),
      .o_valid (w_v[s+1]),
      .o_data  (w_d[s+1])
    );
  end

  logic [NUM_PATHS-1:0][WIDTH-1:0] w_tail;
  logic  w_ne1;
  logic  w_ne2;
  logic  w_ne3;
  path_e w_first;

  assign w_tail    = w_d[DEPTH];
  assign out_valid = w_v[DEPTH];
  assign out_data  = w_tail[0];

  // If-statements route an unknown comparison result to the else arm, so X never flags in the default build.
  always_comb begin
    w_ne1 = 1'b0;
    w_ne2 = 1'b0;
    w_ne3 = 1'b0;
`ifdef PATH_EQUIV_XCHK_EN
    if (w_tail[1] !== w_tail[0]) w_ne1 = 1'b1;
    if (w_tail[2] !== w_tail[0]) w_ne2 = 1'b1;
    if (w_tail[3] !== w_tail[0]) w_ne3 = 1'b1;
    if ((^w_tail[0]) === 1'bx)   w_ne3 = 1'b1;
`else
    if (w_tail[1] != w_tail[0]) w_ne1 = 1'b1;
    if (w_tail[2] != w_tail[0]) w_ne2 = 1'b1;
    if (w_tail[3] != w_tail[0]) w_ne3 = 1'b1;
`endif
  end

  always_comb begin
    w_first = PATH_CONT;
    if (w_ne1)      w_first = PATH_PROC;
    else if (w_ne2) w_first = PATH_BUF;
    else if (w_ne3) w_first = PATH_AND;
  end

  assign mismatch = out_valid & (w_ne1 | w_ne2 | w_ne3);

  logic             r_sticky;
  logic [CNT_W-1:0] r_count;
  path_e            r_first;

  // clr_err takes effect first, so a same-cycle mismatch is recorded as a fresh first error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
      r_first  <= PATH_CONT;
    end else begin
      if (clr_err) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
        r_first  <= PATH_CONT;
      end
      if (mismatch) begin
        r_sticky <= 1'b1;
        if (clr_err) begin
          r_count <= CNT_ONE;
        end else if (r_count != CNT_MAX) begin
          r_count <= r_count + CNT_ONE;
        end
        if (clr_err || !r_sticky) begin
          r_first <= w_first;
        end
      end
    end
  end

  assign err_sticky     = r_sticky;
  assign err_count      = r_count;
  assign first_err_path = r_first;

endmodule

// File: tb/tb_path_equiv_pipe.sv
// tb/tb_path_equiv_pipe.sv - directed table-driven bench for path_equiv_pipe (default build)
module tb_path_equiv_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] inj_mask;
  logic       clr_err;
  logic       out_valid;
  logic [7:0] out_data;
  logic       mismatch;
  logic       err_sticky;
  logic [3:0] err_count;
  logic [1:0] first_err_path;

  int n_tests;
  int n_fail;

  path_equiv_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .inj_mask       (inj_mask),
    .clr_err        (clr_err),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .mismatch       (mismatch),
    .err_sticky     (err_sticky),
    .err_count      (err_count),
    .first_err_path (first_err_path)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] m;
    logic       clr;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_mis;
    logic       e_st;
    logic [3:0] e_cnt;
    logic [1:0] e_fp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t r);
    chk({tag, ".out_valid"},  32'(out_valid),      32'(r.e_ov));
    chk({tag, ".out_data"},   32'(out_data),       32'(r.e_od));
    chk({tag, ".mismatch"},   32'(mismatch),       32'(r.e_mis));
    chk({tag, ".err_sticky"}, 32'(err_sticky),     32'(r.e_st));
    chk({tag, ".err_count"},  32'(err_count),      32'(r.e_cnt));
    chk({tag, ".first_path"}, 32'(first_err_path), 32'(r.e_fp));
  endtask

  initial begin
    vec_t z;
    n_tests = 0;
    n_fail  = 0;

    //            v     d      m      clr   ov    od     mis   st    cnt   fp
    tbl[0] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[1] = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[2] = '{1'b1, 8'h3C, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[5] = '{1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0, 2'd0};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 4'd0, 2'd0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 4'd1, 2'd3};
    tbl[8] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 4'd1, 2'd3};
    tbl[9] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 4'd0, 2'd0};

    // Reset held with a live input: nothing may get through.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; inj_mask = 8'h00; clr_err = 1'b0;
    repeat (3) tick();
    z = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0};
    chk_all("reset", z);

    rst_n = 1'b1;
    tick();
    chk("latency.edge1", 32'(out_valid), 32'd0);
    tick();
    chk("latency.edge2", 32'(out_valid), 32'd1);
    chk("latency.data",  32'(out_data),  32'hA5);
    in_valid = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; inj_mask = tbl[i].m; clr_err = tbl[i].clr;
      tick();
      chk_all($sformatf("row%0d", i), tbl[i]);
    end
    in_valid = 1'b0; inj_mask = 8'h00; clr_err = 1'b0;

    // Saturation: 20 injected words back to back.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'(i); inj_mask = 8'h80;
      tick();
    end
    in_valid = 1'b0; inj_mask = 8'h00;
    repeat (2) tick();
    chk("sat.count",  32'(err_count),      32'd15);
    chk("sat.sticky", 32'(err_sticky),     32'd1);
    chk("sat.first",  32'(first_err_path), 32'd3);

    // clr_err coincident with a mismatching tail word.
    in_valid = 1'b1; in_data = 8'h55; inj_mask = 8'h10;
    tick();
    in_valid = 1'b0; inj_mask = 8'h00;
    tick();
    chk("clrmis.mismatch", 32'(mismatch), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clrmis.count",  32'(err_count),      32'd1);
    chk("clrmis.sticky", 32'(err_sticky),     32'd1);
    chk("clrmis.first",  32'(first_err_path), 32'd3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Bubble then asynchronous reset between edges.
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0;                  tick();
    chk("bubble.v1",   32'(out_valid), 32'd1);
    chk("bubble.d1",   32'(out_data),  32'h11);
    in_valid = 1'b1; in_data = 8'h22; tick();
    chk("bubble.gap",  32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.data",  32'(out_data),  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst.stale%0d", i), 32'(out_valid), 32'd0);
    end

    // Unknown input word on one valid beat.
    in_valid = 1'b1; in_data = 8'bx; tick();
    in_valid = 1'b0; in_data = 8'h00; tick();
`ifdef PATH_EQUIV_XCHK_EN
    chk("xchk.mismatch", 32'(mismatch), 32'd1);
    tick();
    chk("xchk.first", 32'(first_err_path), 32'd3);
`else
    chk("xchk.mismatch", 32'(mismatch),   32'd0);
    tick();
    chk("xchk.sticky",   32'(err_sticky), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
